// File: rtl/macc_pkg.sv
// Shared types and widths for the MACC operand-fetch address path.
package macc_pkg;
    localparam int ADDR_W_DEF = 20;
    localparam int IDX_W      = 10;
    localparam int PROD_W     = 2 * IDX_W;
    localparam int SUM_W      = PROD_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} agen_state_t;
endpackage

// File: rtl/mat_addr_gen_if.sv
// Address output channel towards the operand-memory read port (valid/ready).
interface mat_addr_gen_if
    import macc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W-1:0] out_addr;

    modport master (output out_valid, out_addr, out_last, input out_ready);
    modport slave  (input out_valid, out_addr, out_last, output out_ready);
endinterface

// File: rtl/agen_pipe.sv
// Two-stage address pipeline: stage 1 forms row*stride+col, stage 2 adds base.
// A low enable freezes both stages so the output holds under backpressure.
module agen_pipe
    import macc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    input  logic [IDX_W-1:0]  stride,
    input  logic [ADDR_W-1:0] base,
    output logic              s1_valid,
    output logic              out_valid,
    output logic              out_last,
    output logic [ADDR_W-1:0] out_addr
);
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [SUM_W-1:0]  s1_sum_q, s1_sum_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [PROD_W-1:0] prod;

    always_comb begin
        prod        = PROD_W'(row) * PROD_W'(stride);
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_addr_d  = out_addr_q;
        if (en) begin
            s1_valid_d  = in_valid;
            s1_last_d   = in_valid && in_last;
            s1_sum_d    = SUM_W'(prod) + SUM_W'(col);
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            // Final add wraps modulo 2^ADDR_W by truncation.
            out_addr_d  = base + ADDR_W'(s1_sum_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign s1_valid  = s1_valid_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_addr  = out_addr_q;
endmodule

// File: rtl/mat_addr_gen.sv
// Row-major matrix walker: drives the external 2D counter via inc and turns
// each (row, col) into base + row*stride + col on a valid/ready channel.
module mat_addr_gen
    import macc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  stride,
    input  logic [IDX_W-1:0]  row_max,
    input  logic [IDX_W-1:0]  col_max,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    output logic              inc,
    output logic              busy,
    output logic              done,
    mat_addr_gen_if.master    out_if
);
    agen_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  stride_q, stride_d;
    logic              advance, issue, is_last;
    logic              s1_valid, pipe_valid, pipe_last;
    logic [ADDR_W-1:0] pipe_addr;

    // Whole pipeline moves together; no skid buffer, so stall reaches inc combinationally.
    assign advance = !pipe_valid || out_if.out_ready;
    assign issue   = (state_q == RUN) && advance;
    assign is_last = (row == row_max) && (col == col_max);

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q  <= IDLE;
            base_q   <= '0;
            stride_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            stride_q <= stride_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        stride_d = stride_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                base_d   = base;
                stride_d = stride;
            end
            RUN:     if (issue && is_last) state_d = DRAIN;
            DRAIN:   if (!s1_valid && advance) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inc  = issue;
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    agen_pipe #(.ADDR_W(ADDR_W)) u_pipe (
        .clk       (CLK),
        .rst_n     (RST_L),
        .en        (advance),
        .in_valid  (issue),
        .in_last   (is_last),
        .row       (row),
        .col       (col),
        .stride    (stride_q),
        .base      (base_q),
        .s1_valid  (s1_valid),
        .out_valid (pipe_valid),
        .out_last  (pipe_last),
        .out_addr  (pipe_addr)
    );

    assign out_if.out_valid = pipe_valid;
    assign out_if.out_last  = pipe_last;
    assign out_if.out_addr  = pipe_addr;
endmodule

// File: doc/mat_addr_gen.md
# mat_addr_gen

Sequencer and address generator that walks a matrix in row-major order by driving the `inc` input of the 2D row/column counter and consuming its `row`/`col` outputs. It turns each (row, col) into a linear memory address `base + row*stride + col` through a two-stage pipeline. It presents the addresses to the operand-memory read port over a valid/ready handshake and flags the final element. It sits between the MACC control sequencer (start/done) and the operand fetch path.

## Interface
- `ADDR_W`, default 20: output address width. Arithmetic wraps modulo 2^ADDR_W.
- `CLK`  in  1  clock.
- `RST_L`  in  1  reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to walk the matrix. Sampled only in IDLE.
- `base`  in  ADDR_W  matrix base address. Latched on accepted start.
- `stride`  in  10  words per memory row. Latched on accepted start.
- `row_max`  in  10  last row index. Held stable from start until done.
- `col_max`  in  10  last column index. Held stable from start until done.
- `row`  in  10  current row from the counter.
- `col`  in  10  current column from the counter.
- `inc`  out  1  advance request to the counter.
- `out_valid`  out  1  address valid.
- `out_ready`  in  1  consumer accepts the address.
- `out_addr`  out  ADDR_W  linear address.
- `out_last`  out  1  qualifies the final address of the walk.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the walk has fully drained.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on issue of element (row_max, col_max).
  - DRAIN → DONE when the pipeline is empty, including acceptance of the last output.
  - DONE → IDLE unconditionally.
- `start` outside IDLE is ignored.
- `advance = !out_valid || out_ready`. When advance is low, the whole pipeline stalls.
- Issue: in RUN with advance high, `inc`=1 and stage 1 captures `row*stride + col` (20-bit product plus col, 21-bit sum) and `last = (row==row_max && col==col_max)`.
- `inc` is never high outside RUN or while stalled.
- The final issue also pulses `inc`. This wraps the counter to (0,0), so the next walk needs no clear.
- Stage 2 (output regs): on advance, `out_addr = (base_q + s1_sum) mod 2^ADDR_W`, `out_valid = s1_valid`, `out_last = s1_last`.
- In DRAIN, stage 1 loads invalid bubbles.
- While `out_valid && !out_ready`, `out_addr` and `out_last` are held stable.
- `out_valid` never drops without acceptance.
- Degenerate 1x1 (row_max=col_max=0): exactly one address, with `out_last`=1.
- Reset mid-walk: all state clears asynchronously. The counter shares `RST_L`, so the next start begins at (0,0).

## Timing
- Reset values: `inc`, `out_valid`, `out_last`, `busy`, `done` are 0; `out_addr` is 0; state is IDLE.
- `start` high at edge k → RUN and first `inc` in cycle k+1. The counter shows the next (row, col) in cycle k+2.
- First `out_valid` in cycle k+3, i.e. latency 2 cycles from issue to output.
- Throughput is one address per cycle with `out_ready` held high.
- An N-element walk without backpressure:
  - `out_valid` is high for N consecutive cycles, starting at k+3.
  - The last address is accepted in cycle k+2+N.
  - `done` pulses in cycle k+3+N; `busy` is low from that cycle.
- The stall response is combinational from `out_ready` to `inc`. There is no skid buffer.

## Structure
- Shared package `macc_pkg`:
  - `ADDR_W_DEF`=20
  - `IDX_W`=10
  - enum `agen_state_t` {IDLE, RUN, DRAIN, DONE}
- Sub-module `agen_pipe`: two-stage multiply-add pipeline with valid/last sideband and stall enable. The FSM and issue logic stay in the top level.

## Test plan
- Walk 2x3 (row_max=1, col_max=2), base=0x100, stride=8, `out_ready`=1:
  - Addresses in order: 0x100, 0x101, 0x102, 0x108, 0x109, 0x10A.
  - `out_last` only on 0x10A.
  - `done` one cycle after 0x10A; 6 `inc` pulses.
- Same walk with `out_ready` low for 3 cycles on the second address:
  - 0x101 held stable for those 3 cycles.
  - No `inc` while stalled; no address lost or duplicated.
- 1x1 walk, base=0x55:
  - Single output 0x55 with `out_last`=1.
  - `done` follows; counter back at (0,0).
- `start` pulsed mid-walk: ignored, sequence unchanged. Second start after `done` repeats the sequence.
- Base=0xFFFFE, stride=2, 2x2 walk: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 (wrap).
- `RST_L` asserted during RUN:
  - Outputs go to 0 immediately.
  - After release, a new 2x2 walk starts from (0,0) with correct addresses.
